// File: rtl/alu_flag_unit.sv
// Condition-flag register (Z, N, V, C) fed by the EX-stage adder, plus a
// one-cycle branch resolver that forwards flags written in the same cycle.
module alu_flag_unit #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   input  logic [OPW-1:0]   alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   input  logic             alu_ovfl,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [2:0]       br_cond,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             flag_c,
   output logic             br_done,
   output logic             br_taken
);

   localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0000);
   localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0001);
   localparam logic [OPW-1:0] OP_XOR = OPW'(4'b0010);
   localparam logic [OPW-1:0] OP_SLL = OPW'(4'b0100);
   localparam logic [OPW-1:0] OP_SRA = OPW'(4'b0101);
   localparam logic [OPW-1:0] OP_ROR = OPW'(4'b0110);

   function automatic logic cond_eval(input logic [2:0] cond, input logic z,
                                      input logic n, input logic v);
      logic r;
      case (cond)
         3'b000:  r = ~z;
         3'b001:  r = z;
         3'b010:  r = ~z & ~n;
         3'b011:  r = n;
         3'b100:  r = z | ~n;
         3'b101:  r = n | z;
         3'b110:  r = v;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   logic upd_all, upd_z, alu_fire;
   logic z_fwd, n_fwd, v_fwd, c_fwd, taken_fwd;

   // Flag-write decode and same-cycle forwarding into the branch resolver
   always_comb begin
      upd_all  = (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB);
      upd_z    = upd_all || (alu_opcode == OP_XOR) || (alu_opcode == OP_SLL) ||
                 (alu_opcode == OP_SRA) || (alu_opcode == OP_ROR);
      alu_fire = alu_valid & ~stall;
      z_fwd    = (alu_fire && upd_z)   ? (alu_result == '0)      : flag_z;
      n_fwd    = (alu_fire && upd_all) ? alu_result[WIDTH-1]     : flag_n;
      v_fwd    = (alu_fire && upd_all) ? alu_ovfl                : flag_v;
      c_fwd    = (alu_fire && upd_all) ? alu_cout                : flag_c;
      taken_fwd = cond_eval(br_cond, z_fwd, n_fwd, v_fwd);
   end

   // Registered flags and branch response; stall freezes everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
         flag_v   <= 1'b0;
         flag_c   <= 1'b0;
         br_done  <= 1'b0;
         br_taken <= 1'b0;
      end else if (!stall) begin
         flag_z  <= z_fwd;
         flag_n  <= n_fwd;
         flag_v  <= v_fwd;
         flag_c  <= c_fwd;
         br_done <= br_valid;
         if (br_valid) br_taken <= taken_fwd;
      end
   end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Consumes the result side of the 16-bit CLA add/sub datapath: sum, cout and ovfl, plus the ALU opcode.
- Maintains the processor condition-flag register (Z, N, V, C).
- Resolves conditional branches against those flags and returns a registered taken/not-taken response.
- Sits between the EX-stage ALU and the branch/PC-select logic.

Parameters:
- WIDTH, 16, ALU result width; N is taken from bit WIDTH-1.
- OPW, 4, opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- alu_valid  input  1  ALU result and opcode valid this cycle.
- alu_opcode  input  OPW  opcode of the instruction producing the result.
- alu_result  input  WIDTH  ALU sum/result.
- alu_cout  input  1  adder carry-out.
- alu_ovfl  input  1  adder signed overflow.
- stall  input  1  pipeline stall; freezes flags and branch response.
- br_valid  input  1  branch request this cycle.
- br_cond  input  3  branch condition code.
- flag_z  output  1  registered zero flag.
- flag_n  output  1  registered negative flag.
- flag_v  output  1  registered overflow flag.
- flag_c  output  1  registered carry flag.
- br_done  output  1  one-cycle pulse: branch response valid.
- br_taken  output  1  branch decision, meaningful when br_done=1.

Behaviour:
- Reset: on a clk edge with rst_n=0, clear flag_z, flag_n, flag_v, flag_c, br_done and br_taken to 0. Reset wins over every other input. Reset mid-stall or mid-branch discards the pending response.
- Flag update happens on the clk edge when alu_valid=1, stall=0 and rst_n=1. Update classes:
  - 0000 ADD, 0001 SUB: update all flags. Z = (alu_result==0); N = alu_result[WIDTH-1]; V = alu_ovfl; C = alu_cout.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: update Z only. N, V and C hold.
  - All other opcodes: no flag change.
- When N and V are both updated, the flags reflect the wrapped result bit, not the true sign. Example: ADD 0x7FFF+0x0001 gives N=1, V=1.
- Branch evaluation uses the effective flags:
  - If alu_valid=1 and stall=0 in the same cycle as br_valid, use the flags being written this cycle (forwarded, per the class rules above).
  - Otherwise use the registered flags.
- Condition codes:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: N | Z
  - 110 OV: V
  - 111 UNCOND: 1
- Branch latency is 1 cycle. br_valid=1 and stall=0 at edge k gives br_done=1 and br_taken=decision during cycle k+1. br_done is 0 on every other cycle. br_taken holds its last value when br_done=0.
- stall=1: flags, br_done and br_taken hold their current values. A br_valid or alu_valid presented while stall=1 is ignored; the requester re-presents it. If br_done was 1 entering a stall, it stays 1 until the stall clears, then drops on the next edge.
- Back-to-back branches on consecutive cycles each produce their own br_done pulse, so br_done stays 1 continuously.
- No handshake back-pressure exists beyond stall. The block never blocks the ALU.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with alu_valid=1, ADD, result 0x0000 -> all flags 0, br_done=0 after each edge.
- ADD overflow: result 0x8000, ovfl=1, cout=0 -> Z=0 N=1 V=1 C=0. Then XOR with result 0x0000 -> Z=1, N=1 V=1 C=0 unchanged.
- Forwarding: SUB with result 0x0000 and br_valid with cond 001 (EQ) in the same cycle, old Z=0 -> next cycle br_done=1, br_taken=1.
- All conditions: set flags Z=0 N=1 V=0, then issue cond 000..111 back-to-back -> taken = 1,0,0,1,0,1,0,1 with br_done high for 8 consecutive cycles.
- Stall: stall=1 while presenting ADD result 0x0001 and a branch -> flags and br_done unchanged. Release stall without re-presenting -> br_done=0, flags unchanged.
- Non-flag opcode: opcode 1000 with result 0x0000 -> Z unchanged; a following EQ branch uses the old Z.
